// File: rtl/router_reg_param_if.sv
// Bundle of control, data and status signals between the router FSM,
// the input source and the register stage.
//   master : the FSM/source side; it drives pkt_valid, data_in, fifo_full,
//            the state strobes and rst_int_reg, and reads the status.
//   slave  : the register stage; it reads the controls and drives dout,
//            parity_done, low_pkt_valid, err, err_code and pay_cnt.
interface router_reg_param_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 2
);
    logic                       pkt_valid;
    logic [WIDTH-1:0]           data_in;
    logic                       fifo_full;
    logic                       detect_add;
    logic                       lfd_state;
    logic                       ld_state;
    logic                       laf_state;
    logic                       full_state;
    logic                       rst_int_reg;
    logic [WIDTH-1:0]           dout;
    logic                       parity_done;
    logic                       low_pkt_valid;
    logic                       err;
    logic [1:0]                 err_code;
    logic [WIDTH-ADDR_BITS-1:0] pay_cnt;

    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err, err_code, pay_cnt
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err, err_code, pay_cnt
    );
endinterface

// File: rtl/router_reg_param.sv
// Router register stage between the router FSM and the destination FIFOs.
// Latches the header, steers header/payload/held byte onto dout, keeps a
// byte captured while the FIFO is full, accumulates a check value (XOR
// parity or additive checksum), and after the check byte is delivered
// compares both the check byte and the declared payload length, reporting
// a sticky typed error.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous reset, active high (1 resets)
//   bus    : slave side of router_reg_param_if (controls in, status out)
module router_reg_param #(
    parameter int WIDTH       = 8,
    parameter int ADDR_BITS   = 2,
    parameter int PARITY_MODE = 0
) (
    input  logic               clock,
    input  logic               resetn,
    router_reg_param_if.slave  bus
);
    localparam int LW = WIDTH - ADDR_BITS;

    logic [WIDTH-1:0] hdr_reg;
    logic [WIDTH-1:0] full_reg;
    logic [WIDTH-1:0] int_chk;
    logic [WIDTH-1:0] pkt_chk;
    logic             checked;

    logic [WIDTH-1:0] chk_next;
    logic [1:0]       code_next;

    always_comb begin
        chk_next = int_chk ^ bus.data_in;
        if (PARITY_MODE == 1) begin
            chk_next = int_chk + bus.data_in;
        end
        code_next = {(bus.pay_cnt != hdr_reg[WIDTH-1:ADDR_BITS]),
                     (pkt_chk != int_chk)};
    end

    // Data path: header latch, output byte steering, held byte.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            hdr_reg  <= '0;
            full_reg <= '0;
            bus.dout <= '0;
        end else if (bus.detect_add) begin
            if (bus.pkt_valid) begin
                hdr_reg <= bus.data_in;
            end
        end else if (bus.lfd_state) begin
            bus.dout <= hdr_reg;
        end else if (bus.ld_state) begin
            if (bus.fifo_full) begin
                full_reg <= bus.data_in;
            end else begin
                bus.dout <= bus.data_in;
            end
        end else if (bus.laf_state) begin
            bus.dout <= full_reg;
        end
    end

    // Check path. Only ld_state accumulates and counts, so a byte replayed
    // from full_reg in laf_state is never folded in twice. The compare runs
    // once, the cycle after parity_done is first seen, independent of the
    // state strobes (except detect_add, which restarts the packet).
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            int_chk         <= '0;
            pkt_chk         <= '0;
            checked         <= 1'b0;
            bus.pay_cnt     <= '0;
            bus.parity_done <= 1'b0;
            bus.err         <= 1'b0;
            bus.err_code    <= '0;
        end else if (bus.detect_add) begin
            int_chk         <= '0;
            checked         <= 1'b0;
            bus.pay_cnt     <= '0;
            bus.parity_done <= 1'b0;
            bus.err         <= 1'b0;
            bus.err_code    <= '0;
        end else begin
            if (bus.lfd_state) begin
                int_chk <= hdr_reg;
            end else if (bus.ld_state) begin
                if (bus.pkt_valid) begin
                    int_chk <= chk_next;
                    if (bus.pay_cnt != '1) begin
                        bus.pay_cnt <= bus.pay_cnt + LW'(1);
                    end
                end else begin
                    pkt_chk <= bus.data_in;
                    if (!bus.fifo_full) begin
                        bus.parity_done <= 1'b1;
                    end
                end
            end else if (bus.laf_state) begin
                if (bus.low_pkt_valid && !bus.parity_done) begin
                    bus.parity_done <= 1'b1;
                end
            end

            if (bus.parity_done && !checked) begin
                bus.err_code <= code_next;
                bus.err      <= |code_next;
                checked      <= 1'b1;
            end
        end
    end

    // End-of-packet flag; the clear request wins over a new check byte.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            bus.low_pkt_valid <= 1'b0;
        end else if (bus.rst_int_reg) begin
            bus.low_pkt_valid <= 1'b0;
        end else if (!bus.detect_add && !bus.lfd_state && bus.ld_state &&
                     !bus.pkt_valid) begin
            bus.low_pkt_valid <= 1'b1;
        end else if (bus.full_state) begin
            // Stalled on a full FIFO: the flag holds while the byte waits.
            bus.low_pkt_valid <= bus.low_pkt_valid;
        end
    end
endmodule
